// File: rtl/memory_arbiter_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : memory_arbiter_multi
// Brief    : Arbitrates NCH burst requestors onto one main-memory port with
//            fixed-priority or round-robin selection and a wait-state
//            watchdog that aborts hung transfers.
// Revision : 1.0 - initial release
// ============================================================================
module memory_arbiter_multi #(
    parameter int NCH     = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int LEN_W   = 2,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NCH-1:0]          req,
    input  logic [NCH-1:0]          req_wen,
    input  logic [NCH*ADDR_W-1:0]   req_addr,
    input  logic [NCH*LEN_W-1:0]    req_len,
    input  logic [NCH*DATA_W-1:0]   req_wdata,
    output logic [NCH-1:0]          grant,
    output logic [NCH-1:0]          beat,
    output logic [LEN_W-1:0]        beat_idx,
    output logic [DATA_W-1:0]       rdata,
    output logic [NCH-1:0]          done,
    output logic [NCH-1:0]          err,
    output logic                    ram_ren,
    output logic                    ram_wen,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       ram_store,
    input  logic [DATA_W-1:0]       ram_load,
    input  logic                    ram_wait
);

    localparam int                  c_PTR_W     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int                  c_WAIT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit                  c_WD_EN     = (TIMEOUT > 0);
    localparam logic [ADDR_W-1:0]   c_STEP      = ADDR_W'(DATA_W / 8);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [c_PTR_W-1:0]  c_LAST_CH   = c_PTR_W'(NCH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [NCH-1:0]         r_grant;
    logic [c_PTR_W-1:0]     r_owner;
    logic                   r_wen;
    logic [ADDR_W-1:0]      r_base;
    logic [LEN_W-1:0]       r_len;
    logic [LEN_W-1:0]       r_cnt;
    logic [c_WAIT_W-1:0]    r_wait_cnt;
    logic [c_PTR_W-1:0]     r_ptr;
    logic [NCH-1:0]         r_beat;
    logic [LEN_W-1:0]       r_beat_idx;
    logic [DATA_W-1:0]      r_rdata;
    logic [NCH-1:0]         r_done;
    logic [NCH-1:0]         r_err;
    logic                   r_ram_ren;
    logic                   r_ram_wen;

    logic                   w_any;
    logic [c_PTR_W-1:0]     w_win;
    logic [c_PTR_W-1:0]     w_cand;
    logic [DATA_W-1:0]      w_store;

    // Winner selection: scan starts at the RR pointer (or 0 in fixed mode) and wraps
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_cand = '0;
        for (int i = 0; i < NCH; i++) begin
            if (RR_MODE != 0) begin
                w_cand = c_PTR_W'((int'(r_ptr) + i) % NCH);
            end else begin
                w_cand = c_PTR_W'(i);
            end
            if (!w_any && req[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end
        end
    end

    // Write data follows the granted slice live so the owner can stream beats
    always_comb begin
        w_store = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_grant[i]) begin
                w_store = w_store | req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Burst FSM: latch request in IDLE, stream beats in BUSY, report in DONE
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_owner    <= '0;
            r_wen      <= 1'b0;
            r_base     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_wait_cnt <= '0;
            r_ptr      <= '0;
            r_beat     <= '0;
            r_beat_idx <= '0;
            r_rdata    <= '0;
            r_done     <= '0;
            r_err      <= '0;
            r_ram_ren  <= 1'b0;
            r_ram_wen  <= 1'b0;
        end else begin
            r_beat <= '0;
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant    <= NCH'(1) << w_win;
                        r_owner    <= w_win;
                        r_wen      <= req_wen[w_win];
                        r_base     <= req_addr[w_win*ADDR_W +: ADDR_W];
                        r_len      <= req_len[w_win*LEN_W +: LEN_W];
                        r_cnt      <= '0;
                        r_wait_cnt <= '0;
                        r_ram_ren  <= ~req_wen[w_win];
                        r_ram_wen  <= req_wen[w_win];
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!ram_wait) begin
                        r_beat     <= r_grant;
                        r_beat_idx <= r_cnt;
                        r_wait_cnt <= '0;
                        if (!r_wen) begin
                            r_rdata <= ram_load;
                        end
                        if (r_cnt == r_len) begin
                            r_ram_ren <= 1'b0;
                            r_ram_wen <= 1'b0;
                            r_done    <= r_grant;
                            r_cnt     <= '0;
                            r_state   <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (c_WD_EN && (r_wait_cnt == c_WAIT_LAST)) begin
                        // Hung beat: abort without DONE so the RR pointer keeps its place
                        r_ram_ren  <= 1'b0;
                        r_ram_wen  <= 1'b0;
                        r_err      <= r_grant;
                        r_grant    <= '0;
                        r_cnt      <= '0;
                        r_wait_cnt <= '0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_grant <= '0;
                    r_ptr   <= (r_owner == c_LAST_CH) ? '0 : r_owner + 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign beat      = r_beat;
    assign beat_idx  = r_beat_idx;
    assign rdata     = r_rdata;
    assign done      = r_done;
    assign err       = r_err;
    assign ram_ren   = r_ram_ren;
    assign ram_wen   = r_ram_wen;
    assign ram_addr  = r_base + (ADDR_W'(r_cnt) * c_STEP);
    assign ram_store = w_store;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_memory_arbiter_multi
// Brief    : Self-checking bench for memory_arbiter_multi (round-robin DUT with
//            a short watchdog plus a fixed-priority DUT on shared stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter_multi;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  idx;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic        wen;
    } acc_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [3:0]    req = '0;
    logic [3:0]    req_wen = '0;
    logic [127:0]  req_addr = '0;
    logic [7:0]    req_len = '0;
    logic [255:0]  req_wdata = '0;
    logic [63:0]   ram_load = '0;
    logic          ram_wait = 1'b0;

    logic [3:0]    grant, beat, done, err;
    logic [1:0]    beat_idx;
    logic [63:0]   rdata, ram_store;
    logic          ram_ren, ram_wen;
    logic [31:0]   ram_addr;

    logic [3:0]    grant_f, beat_f, done_f, err_f;
    logic [1:0]    beat_idx_f;
    logic [63:0]   rdata_f, ram_store_f;
    logic          ram_ren_f, ram_wen_f;
    logic [31:0]   ram_addr_f;

    int            total = 0;
    int            bad = 0;
    int            mode = 0;      // 0: never wait, 1: one wait per beat, 2: always wait
    logic          waited = 1'b0;
    exp_t          exp_q[$];
    acc_t          acc_q[$];
    acc_t          acc_tmp;

    memory_arbiter_multi #(
        .NCH(4), .ADDR_W(32), .DATA_W(64), .LEN_W(2), .RR_MODE(1), .TIMEOUT(4)
    ) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_wen(req_wen), .req_addr(req_addr),
        .req_len(req_len), .req_wdata(req_wdata), .grant(grant), .beat(beat),
        .beat_idx(beat_idx), .rdata(rdata), .done(done), .err(err),
        .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
        .ram_store(ram_store), .ram_load(ram_load), .ram_wait(ram_wait)
    );

    memory_arbiter_multi #(
        .NCH(4), .ADDR_W(32), .DATA_W(64), .LEN_W(2), .RR_MODE(0), .TIMEOUT(255)
    ) dut_f (
        .CLK(CLK), .RST(RST), .req(req), .req_wen(req_wen), .req_addr(req_addr),
        .req_len(req_len), .req_wdata(req_wdata), .grant(grant_f), .beat(beat_f),
        .beat_idx(beat_idx_f), .rdata(rdata_f), .done(done_f), .err(err_f),
        .ram_ren(ram_ren_f), .ram_wen(ram_wen_f), .ram_addr(ram_addr_f),
        .ram_store(ram_store_f), .ram_load(ram_load), .ram_wait(ram_wait)
    );

    always #5 CLK = ~CLK;

    // Memory contents: word at address a holds (a >> 3) + 0x80
    function automatic logic [63:0] mem_word(input logic [31:0] a);
        return 64'(a[31:3]) + 64'h80;
    endfunction

    // Memory responder for the main DUT: drives wait/load mid-cycle, logs accepted beats
    always @(negedge CLK) begin
        if (ram_ren || ram_wen) begin
            ram_load = mem_word(ram_addr);
            if (mode == 0) begin
                ram_wait = 1'b0;
            end else if (mode == 1) begin
                ram_wait = ~waited;
                waited   = ~waited;
            end else begin
                ram_wait = 1'b1;
            end
            if (!ram_wait) begin
                acc_tmp.addr = ram_addr;
                acc_tmp.data = ram_wen ? ram_store : ram_load;
                acc_tmp.wen  = ram_wen;
                acc_q.push_back(acc_tmp);
            end
        end else begin
            ram_wait = 1'b0;
            waited   = 1'b0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        req = '0;
        req_wen = '0;
        mode = 0;
        tick();
        tick();
        RST = 1'b0;
        tick();
        acc_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        mode = 2;
        req_addr[63:32] = 32'h100;
        req_len[3:2] = 2'd3;
        req = 4'b0010;
        tick(); tick(); tick();
        total++;
        if (ram_ren !== 1'b1) begin
            bad++; $display("FAIL rst_pre_busy: ram_ren got %b want 1", ram_ren);
        end
        RST = 1'b1;
        #1;
        total++;
        if ({grant, beat, beat_idx, rdata, done, err, ram_ren, ram_wen, ram_addr, ram_store} !== '0) begin
            bad++; $display("FAIL rst_async: outputs got grant=%b ren=%b addr=%h want all 0", grant, ram_ren, ram_addr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({grant, beat, beat_idx, rdata, done, err, ram_ren, ram_wen, ram_addr, ram_store,
                 grant_f, beat_f, beat_idx_f, rdata_f, done_f, err_f, ram_ren_f, ram_wen_f,
                 ram_addr_f, ram_store_f} !== '0) begin
                bad++; $display("FAIL rst_hold: grant=%b grant_f=%b ren=%b addr=%h want all 0", grant, grant_f, ram_ren, ram_addr);
            end
        end
        RST = 1'b0;
        req = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({done, err, grant, done_f, err_f, ram_ren, ram_wen} !== '0) begin
                bad++; $display("FAIL rst_after: done=%b err=%b grant=%b want 0", done, err, grant);
            end
        end
    endtask

    task automatic test_single_latency();
        do_reset();
        mode = 0;
        req_addr[31:0] = 32'h8;
        req_len[1:0] = 2'd0;
        req_wen = 4'b0000;
        req = 4'b0001;
        tick();
        total++;
        if ({grant, ram_ren, ram_wen, beat, done} !== {4'b0001, 1'b1, 1'b0, 4'b0000, 4'b0000}) begin
            bad++; $display("FAIL lat_strobe: grant=%b ren=%b wen=%b beat=%b done=%b want 0001 1 0 0000 0000", grant, ram_ren, ram_wen, beat, done);
        end
        tick();
        total++;
        if ({grant, beat, done, ram_ren} !== {4'b0001, 4'b0001, 4'b0001, 1'b0}) begin
            bad++; $display("FAIL lat_done: grant=%b beat=%b done=%b ren=%b want 0001 0001 0001 0", grant, beat, done, ram_ren);
        end
        total++;
        if (rdata !== 64'h81) begin
            bad++; $display("FAIL lat_rdata: got %h want %h", rdata, 64'h81);
        end
        req = '0;
        tick();
        total++;
        if ({grant, done, beat} !== '0) begin
            bad++; $display("FAIL lat_idle: grant=%b done=%b beat=%b want 0", grant, done, beat);
        end
    endtask

    task automatic test_read_burst();
        exp_t e;
        acc_t a;
        bit   fin;
        do_reset();
        mode = 1;
        for (int i = 0; i < 4; i++) begin
            e.addr = 32'h100 + 32'(8 * i);
            e.data = 64'hA0 + 64'(i);
            e.idx  = 2'(i);
            exp_q.push_back(e);
        end
        req_addr[63:32] = 32'h100;
        req_len[3:2] = 2'd3;
        req_wen = 4'b0000;
        req = 4'b0010;
        fin = 1'b0;
        for (int c = 0; c < 40 && !fin; c++) begin
            tick();
            if (beat !== 4'b0000) begin
                total++;
                if (beat !== 4'b0010) begin
                    bad++; $display("FAIL rd_beat_owner: got %b want 0010", beat);
                end
                total++;
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    bad++; $display("FAIL rd_beat_unexpected: exp=%0d acc=%0d want both >0", exp_q.size(), acc_q.size());
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    total++;
                    if (a.addr !== e.addr || a.wen !== 1'b0) begin
                        bad++; $display("FAIL rd_addr: got %h wen=%b want %h wen=0", a.addr, a.wen, e.addr);
                    end
                    total++;
                    if (rdata !== e.data) begin
                        bad++; $display("FAIL rd_data: got %h want %h", rdata, e.data);
                    end
                    total++;
                    if (beat_idx !== e.idx) begin
                        bad++; $display("FAIL rd_idx: got %0d want %0d", beat_idx, e.idx);
                    end
                end
            end
            if (done !== 4'b0000) begin
                total++;
                if ({done, beat, beat_idx} !== {4'b0010, 4'b0010, 2'd3}) begin
                    bad++; $display("FAIL rd_done: done=%b beat=%b idx=%0d want 0010 0010 3", done, beat, beat_idx);
                end
                fin = 1'b1;
                req = '0;
            end
            if (err !== 4'b0000) begin
                total++; bad++; $display("FAIL rd_err: got %b want 0000", err);
            end
        end
        total++;
        if (!fin || exp_q.size() != 0) begin
            bad++; $display("FAIL rd_complete: done_seen=%0d left=%0d want 1 0", fin, exp_q.size());
        end
    endtask

    task automatic test_write_wrap();
        exp_t e;
        acc_t a;
        bit   fin;
        do_reset();
        mode = 0;
        e.addr = 32'hFFFF_FFF8; e.data = 64'h1111_2222_3333_4444; e.idx = 2'd0; exp_q.push_back(e);
        e.addr = 32'h0000_0000; e.data = 64'h5555_6666_7777_8888; e.idx = 2'd1; exp_q.push_back(e);
        req_addr[127:96] = 32'hFFFF_FFF8;
        req_len[7:6] = 2'd1;
        req_wdata[255:192] = 64'h1111_2222_3333_4444;
        req_wen = 4'b1000;
        req = 4'b1000;
        fin = 1'b0;
        for (int c = 0; c < 30 && !fin; c++) begin
            tick();
            if (beat !== 4'b0000) begin
                total++;
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    bad++; $display("FAIL wr_beat_unexpected: exp=%0d acc=%0d want both >0", exp_q.size(), acc_q.size());
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    total++;
                    if (a.addr !== e.addr || a.wen !== 1'b1) begin
                        bad++; $display("FAIL wr_addr: got %h wen=%b want %h wen=1", a.addr, a.wen, e.addr);
                    end
                    total++;
                    if (a.data !== e.data) begin
                        bad++; $display("FAIL wr_store: got %h want %h", a.data, e.data);
                    end
                    total++;
                    if ({beat, beat_idx} !== {4'b1000, e.idx}) begin
                        bad++; $display("FAIL wr_beat: beat=%b idx=%0d want 1000 %0d", beat, beat_idx, e.idx);
                    end
                    if (e.idx == 2'd0) begin
                        req_wdata[255:192] = 64'h5555_6666_7777_8888;
                    end
                end
            end
            if (done !== 4'b0000) begin
                total++;
                if (done !== 4'b1000) begin
                    bad++; $display("FAIL wr_done: got %b want 1000", done);
                end
                fin = 1'b1;
                req = '0;
                req_wen = '0;
            end
        end
        total++;
        if (!fin || exp_q.size() != 0) begin
            bad++; $display("FAIL wr_complete: done_seen=%0d left=%0d want 1 0", fin, exp_q.size());
        end
    endtask

    task automatic test_fixed_priority();
        logic [3:0] gq[$];
        logic [3:0] prev;
        logic [3:0] eg;
        int         n0;
        bit         fin;
        do_reset();
        mode = 0;
        gq.push_back(4'b0001); gq.push_back(4'b0001); gq.push_back(4'b0100);
        req_len = '0;
        req_wen = '0;
        req = 4'b0101;
        prev = '0; n0 = 0; fin = 1'b0;
        for (int c = 0; c < 40 && !fin; c++) begin
            tick();
            if (grant_f !== 4'b0000 && prev === 4'b0000) begin
                total++;
                if (gq.size() == 0) begin
                    bad++; $display("FAIL fp_extra_grant: got %b want none", grant_f);
                end else begin
                    eg = gq.pop_front();
                    if (grant_f !== eg) begin
                        bad++; $display("FAIL fp_order: got %b want %b", grant_f, eg);
                    end
                end
            end
            if (done_f !== 4'b0000) begin
                total++;
                if (done_f !== grant_f) begin
                    bad++; $display("FAIL fp_done_owner: done=%b grant=%b want equal", done_f, grant_f);
                end
                if (done_f[0]) begin
                    n0++;
                    if (n0 == 2) req[0] = 1'b0;
                end
                if (done_f[2]) begin
                    req[2] = 1'b0;
                    fin = 1'b1;
                end
            end
            prev = grant_f;
        end
        total++;
        if (!fin || gq.size() != 0) begin
            bad++; $display("FAIL fp_complete: finished=%0d grants_left=%0d want 1 0", fin, gq.size());
        end
        req = '0;
    endtask

    task automatic test_round_robin();
        logic [3:0] gq[$];
        logic [3:0] prev;
        logic [3:0] eg;
        int         nseen;
        bit         fin;
        do_reset();
        mode = 0;
        gq.push_back(4'b0001); gq.push_back(4'b0010); gq.push_back(4'b0100);
        gq.push_back(4'b1000); gq.push_back(4'b0001);
        req_len = '0;
        req_wen = '0;
        req = 4'b1111;
        prev = '0; nseen = 0; fin = 1'b0;
        for (int c = 0; c < 60 && !fin; c++) begin
            tick();
            if (grant !== 4'b0000 && prev === 4'b0000) begin
                nseen++;
                total++;
                if (gq.size() == 0) begin
                    bad++; $display("FAIL rr_extra_grant: got %b want none", grant);
                end else begin
                    eg = gq.pop_front();
                    if (grant !== eg) begin
                        bad++; $display("FAIL rr_order: got %b want %b", grant, eg);
                    end
                end
                total++;
                if (!$onehot(grant)) begin
                    bad++; $display("FAIL rr_onehot: got %b want one-hot", grant);
                end
            end
            if (done !== 4'b0000) begin
                total++;
                if (done !== grant) begin
                    bad++; $display("FAIL rr_done_owner: done=%b grant=%b want equal", done, grant);
                end
                if (nseen == 5) begin
                    req = '0;
                    fin = 1'b1;
                end
            end
            prev = grant;
        end
        total++;
        if (!fin || gq.size() != 0) begin
            bad++; $display("FAIL rr_complete: finished=%0d grants_left=%0d want 1 0", fin, gq.size());
        end
    endtask

    task automatic test_watchdog();
        exp_t e;
        acc_t a;
        int   strobes;
        bit   got_err;
        bit   fin;
        do_reset();
        mode = 2;
        e.addr = 32'h200; e.data = 64'hC0; e.idx = 2'd0; exp_q.push_back(e);
        req_addr[31:0] = 32'h40;
        req_addr[63:32] = 32'h200;
        req_len = '0;
        req_wen = '0;
        req = 4'b0011;
        strobes = 0; got_err = 1'b0; fin = 1'b0;
        for (int c = 0; c < 40 && !fin; c++) begin
            tick();
            if (!got_err && (ram_ren || ram_wen)) strobes++;
            if (err !== 4'b0000) begin
                total++;
                if (got_err) begin
                    bad++; $display("FAIL wd_extra_err: got %b want 0000", err);
                end else begin
                    if (err !== 4'b0001) begin
                        bad++; $display("FAIL wd_err_owner: got %b want 0001", err);
                    end
                    total++;
                    if (strobes != 4) begin
                        bad++; $display("FAIL wd_wait_cycles: got %0d want 4", strobes);
                    end
                    total++;
                    if ({ram_ren, ram_wen, done} !== 6'b0) begin
                        bad++; $display("FAIL wd_abort_state: ren=%b wen=%b done=%b want 0 0 0000", ram_ren, ram_wen, done);
                    end
                    got_err = 1'b1;
                    req[0] = 1'b0;
                    mode = 0;
                end
            end
            if (beat !== 4'b0000) begin
                total++;
                if (!got_err || exp_q.size() == 0 || acc_q.size() == 0) begin
                    bad++; $display("FAIL wd_beat_unexpected: beat=%b err_seen=%0d want after err", beat, got_err);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    if ({beat, a.addr, rdata} !== {4'b0010, e.addr, e.data}) begin
                        bad++; $display("FAIL wd_next_beat: beat=%b addr=%h data=%h want 0010 %h %h", beat, a.addr, rdata, e.addr, e.data);
                    end
                end
            end
            if (done !== 4'b0000) begin
                total++;
                if (!got_err || done !== 4'b0010) begin
                    bad++; $display("FAIL wd_done: got %b err_seen=%0d want 0010 after err", done, got_err);
                end
                fin = 1'b1;
                req = '0;
            end
        end
        total++;
        if (!fin || !got_err) begin
            bad++; $display("FAIL wd_complete: err_seen=%0d done_seen=%0d want 1 1", got_err, fin);
        end
    endtask

    initial begin
        test_reset();
        test_single_latency();
        test_read_burst();
        test_write_wrap();
        test_fixed_priority();
        test_round_robin();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t want finished", $time);
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire
